fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 36 +++
 rtl/fetch_unit_if.sv | 26 ++
 rtl/fetch_buffer.sv | 51 +++++
 rtl/fetch_unit.sv | 106 ++++++++++
 tb/tb_fetch_unit.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, reset vector,
// opcode field position and the buffered instruction entry layout.
package fetch_unit_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   localparam logic [1:0] ST_RESET_WAIT = 2'd0;
   localparam logic [1:0] ST_RUN        = 2'd1;
   localparam logic [1:0] ST_FLUSH      = 2'd2;

   localparam int OPCODE_MSB = 6;
   localparam int OPCODE_LSB = 0;

   typedef enum logic [6:0] {
      OP_LOAD   = 7'b0000011,
      OP_IMM    = 7'b0010011,
      OP_AUIPC  = 7'b0010111,
      OP_STORE  = 7'b0100011,
      OP_REG    = 7'b0110011,
      OP_LUI    = 7'b0110111,
      OP_BRANCH = 7'b1100011,
      OP_JALR   = 7'b1100111,
      OP_JAL    = 7'b1101111,
      OP_SYSTEM = 7'b1110011
   } opcode_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   function automatic logic [6:0] opcode_of(input logic [31:0] instr);
      return instr[OPCODE_MSB:OPCODE_LSB];
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response bus between the fetch unit (master) and memory (slave).
interface fetch_unit_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rvalid,
      output imem_rdata
   );

endinterface

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO with a flush input and an occupancy count; DEPTH must be a power of two.
module fetch_buffer #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic                    push,
   input  logic [WIDTH-1:0]        push_data,
   input  logic                    pop,
   output logic [WIDTH-1:0]        head_data,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty     = (count == '0);
   assign do_pop    = pop && !empty;
   assign do_push   = push && ((count != CW'(DEPTH)) || do_pop);
   assign head_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fetch_unit.sv
// Credit-based instruction fetch unit: issues in-order word fetches, buffers responses
// with their pc, and discards in-flight responses after a redirect.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          DEPTH    = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   fetch_unit_if.master        imem,
   input  logic                stall,
   input  logic                redirect_valid,
   input  logic [31:0]         redirect_pc,
   output logic                if_valid,
   output logic [31:0]         if_instr,
   output logic [31:0]         if_pc,
   output logic [6:0]          if_opcode
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int SW = CW + 1;

   logic [1:0]    state;
   logic [1:0]    state_next;
   logic [31:0]   fetch_pc;
   logic [CW-1:0] tag_count;
   logic [CW-1:0] tag_left;
   logic [CW-1:0] buf_count;
   logic [31:0]   tag_head;
   logic          tag_empty;
   logic          buf_empty;
   fetch_entry_t  buf_head;
   fetch_entry_t  buf_wdata;
   logic          redirect;
   logic          resp_taken;
   logic          buf_pop;
   logic          buf_push;
   logic          issue;
   logic [SW-1:0] in_use;

   assign redirect   = redirect_valid && (state != ST_RESET_WAIT);
   assign resp_taken = imem.imem_rvalid && !tag_empty;
   assign tag_left   = tag_count - CW'(resp_taken);
   assign buf_pop    = !buf_empty && !stall && !redirect;
   assign buf_push   = (state == ST_RUN) && resp_taken && !redirect;
   assign buf_wdata  = '{pc: tag_head, instr: imem.imem_rdata};

   // The slot freed by this cycle's pop counts as available, so a single-cycle memory sustains one fetch per clock.
   assign in_use        = SW'(tag_count) + SW'(buf_count) - SW'(buf_pop);
   assign imem.imem_req  = (state == ST_RUN) && !redirect && (in_use < SW'(DEPTH));
   assign imem.imem_addr = fetch_pc;
   assign issue          = imem.imem_req && imem.imem_ready;

   assign if_valid  = !buf_empty;
   assign if_instr  = if_valid ? buf_head.instr : '0;
   assign if_pc     = if_valid ? buf_head.pc : '0;
   assign if_opcode = opcode_of(if_instr);

   always_comb begin
      state_next = state;
      case (state)
         ST_RESET_WAIT: state_next = ST_RUN;
         ST_RUN:        if (redirect && (tag_left != '0)) state_next = ST_FLUSH;
         ST_FLUSH:      if (tag_left == '0) state_next = ST_RUN;
         default:       state_next = ST_RESET_WAIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_RESET_WAIT;
         fetch_pc <= RESET_PC;
      end else begin
         state <= state_next;
         if (redirect) fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
         else if (issue) fetch_pc <= fetch_pc + 32'd4;
      end
   end

   // Tag queue holds the pc of every request still awaiting its response, so its count is the outstanding total.
   fetch_buffer #(.WIDTH(32), .DEPTH(DEPTH)) u_tag_queue (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (1'b0),
      .push      (issue),
      .push_data (fetch_pc),
      .pop       (resp_taken),
      .head_data (tag_head),
      .empty     (tag_empty),
      .count     (tag_count)
   );

   fetch_buffer #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_instr_buffer (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect),
      .push      (buf_push),
      .push_data (buf_wdata),
      .pop       (buf_pop),
      .head_data (buf_head),
      .empty     (buf_empty),
      .count     (buf_count)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model plus a pc-stream reference model.
module tb_fetch_unit;

   localparam int          DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   typedef struct {
      logic [31:0] addr;
      int          due;
      bit          stale;
   } mem_req_t;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [6:0]  if_opcode;

   fetch_unit_if imem ();

   fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem           (imem),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .if_opcode      (if_opcode)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   mem_req_t    pend[$];
   int          cycle;
   int          last_due;
   int          buffered;
   int          valid_cycles;
   int          tests;
   int          fails;
   bit          flushing;
   bit          after_reset;
   logic [31:0] exp_fetch;
   logic [31:0] exp_pc;
   logic [31:0] held_pc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0033;
   endfunction

   function automatic int live_count();
      int n = 0;
      foreach (pend[i]) if (!pend[i].stale) n++;
      return n;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic resetDut();
      @(negedge clk);
      rst_n = 1'b0;
      stall = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      imem.imem_ready = 1'b0;
      imem.imem_rvalid = 1'b0;
      imem.imem_rdata = '0;
      #1;
      checkOutput("rst_imem_req", imem.imem_req, 1'b0);
      checkOutput("rst_imem_addr", imem.imem_addr, RESET_PC);
      checkOutput("rst_if_valid", if_valid, 1'b0);
      checkOutput("rst_if_instr", if_instr, 32'd0);
      checkOutput("rst_if_pc", if_pc, 32'd0);
      checkOutput("rst_if_opcode", if_opcode, 32'd0);
      repeat (3) begin
         @(posedge clk);
         cycle++;
      end
      foreach (pend[i]) pend[i].stale = 1'b1;
      exp_fetch   = RESET_PC;
      exp_pc      = RESET_PC;
      buffered    = 0;
      flushing    = 1'b0;
      after_reset = 1'b1;
      #2 rst_n = 1'b1;
   endtask

   // One clock of stimulus: drive at the falling edge, check and advance the model, then let the rising edge occur.
   task automatic applyStimulus(input bit stl, input bit rdy, input bit redir,
                                input logic [31:0] rpc, input int lat);
      bit          resp;
      bit          pop_now;
      bit          req_exp;
      int          live;
      int          live_after;
      int          due;
      logic [31:0] word;
      mem_req_t    head;
      @(negedge clk);
      stall = stl;
      redirect_valid = redir;
      redirect_pc = rpc;
      imem.imem_ready = rdy;
      resp = (pend.size() > 0) && (pend[0].due <= cycle);
      imem.imem_rvalid = resp;
      imem.imem_rdata = resp ? mem_word(pend[0].addr) : $urandom();
      #1;
      live = live_count();
      pop_now = (buffered > 0) && !stl && !redir;
      req_exp = !after_reset && !flushing && !redir &&
                ((live + buffered - (pop_now ? 1 : 0)) < DEPTH);
      checkOutput("imem_req", imem.imem_req, req_exp);
      if (req_exp) checkOutput("imem_addr", imem.imem_addr, exp_fetch);
      checkOutput("if_valid", if_valid, buffered > 0);
      if (if_valid) valid_cycles++;
      if (buffered > 0) begin
         word = mem_word(exp_pc);
         checkOutput("if_pc", if_pc, exp_pc);
         checkOutput("if_instr", if_instr, word);
         checkOutput("if_opcode", if_opcode, word[6:0]);
      end
      live_after = live;
      if (resp) begin
         head = pend.pop_front();
         if (!head.stale) live_after = live - 1;
      end
      if (pop_now) begin
         buffered--;
         exp_pc += 32'd4;
      end
      if (resp && !head.stale && !flushing && !redir && !after_reset) buffered++;
      if (imem.imem_req && rdy) begin
         due = (cycle + lat > last_due + 1) ? cycle + lat : last_due + 1;
         last_due = due;
         pend.push_back('{addr: imem.imem_addr, due: due, stale: 1'b0});
         exp_fetch += 32'd4;
      end
      if (redir) begin
         buffered  = 0;
         exp_pc    = rpc & 32'hFFFF_FFFC;
         exp_fetch = rpc & 32'hFFFF_FFFC;
         flushing  = (live_after > 0);
      end else if (flushing) begin
         flushing = (live_after > 0);
      end
      after_reset = 1'b0;
      cycle++;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      cycle = 0;
      last_due = -100;
      valid_cycles = 0;
      rst_n = 1'b1;

      // Ideal memory: first instruction visible three samples after reset release, then one per cycle.
      resetDut();
      valid_cycles = 0;
      repeat (12) applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1);
      checkOutput("throughput_valid_cycles", valid_cycles, 32'd9);

      // Stall long enough to fill the buffer, then release.
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1);
      held_pc = if_pc;
      repeat (5) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1);
      checkOutput("stall_if_pc_held", if_pc, held_pc);
      checkOutput("stall_no_req", imem.imem_req, 1'b0);
      repeat (8) applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1);

      // Fetch address wraps past the top of the address space.
      applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 1);
      repeat (8) applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1);

      // Redirect with two requests outstanding: both responses discarded, fetch resumes at 0x100.
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_1000, 3);
      for (int i = 0; i < 10 && live_count() < 2; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 3);
      checkOutput("flush_setup_outstanding", live_count(), 32'd2);
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0102, 3);
      checkOutput("flush_if_valid_cleared", if_valid, 1'b0);
      repeat (12) applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1);

      // Random ready, stall, latency and redirects.
      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(3) == 0, $urandom_range(1) == 1,
                       $urandom_range(19) == 0, $urandom(), $urandom_range(1, 3));
      end

      // Reset with requests in flight; their late responses must be ignored.
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_2000, 3);
      for (int i = 0; i < 20 && live_count() < 2; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 3);
      checkOutput("reset_setup_outstanding", live_count(), 32'd2);
      resetDut();
      repeat (10) applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
